mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Four-requester round-robin arbiter that shares one 4:1 mux tree between requesters and delivers the selected beat on a single registered output channel. It generates the mux select, handshakes with each requester (valid/ready) and with the downstream consumer. It sits in front of any datapath that previously hard-wired a static select into a mux tree.

## Interface

**Parameters**
- `WIDTH`, 8, data width per requester and output.

**Ports**
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `req_valid`, in, 4, per-requester beat valid.
- `req_data`, in, 4*WIDTH, requester i occupies bits [i*WIDTH +: WIDTH].
- `req_last`, in, 4, last beat of a burst (used only with `MUX_ARB_LOCK_EN`).
- `req_ready`, out, 4, one-hot or zero; beat i is accepted when `req_valid[i] & req_ready[i]`.
- `out_valid`, out, 1, output register holds a beat.
- `out_ready`, in, 1, downstream accepts.
- `out_data`, out, WIDTH, registered selected data.
- `out_src`, out, 2, index of the requester that produced `out_data`.

## Operation

- **Pointer and grant.** A 2-bit `prio` register holds the highest-priority index. The combinational grant is the first requester with `req_valid` set, scanning `prio`, `prio+1`, ..., mod 4. `sel` is the 2-bit encoded grant and drives the mux tree.
- **Capacity.** `can_load = ~out_valid | out_ready`.
- **Ready.** `req_ready[g] = can_load & any_valid`; all other `req_ready` bits are 0. `req_ready` never asserts without a matching `req_valid`.
- **On accept** (`req_valid[g] & req_ready[g]`):
  - `out_data` ← mux(`sel`), `out_src` ← `g`, `out_valid` ← 1.
  - `prio` ← `g+1` mod 4; wrap from 3 to 0.
- **On output handshake with no new accept:** `out_valid` ← 0.
- **Simultaneous output drain and new accept** in the same cycle: the new beat replaces the old one, `out_valid` stays 1, and no bubble is inserted.
- **Idle requesters.** If no requester is valid, `prio` is unchanged. Requesters that are not valid are skipped with no penalty.
- **Fairness.** With all four requesters continuously valid, grants rotate 0,1,2,3,0,...; each requester waits at most 3 accepted beats.
- **Reset values:** `out_valid`=0, `out_data`=0, `out_src`=0, `prio`=0, `req_ready`=0 while `rst` is high. Reset mid-burst drops the registered beat and clears the lock.

## Timing

- Latency is 1 cycle: a beat accepted in cycle n is on `out_data` in cycle n+1.
- Throughput is 1 beat/cycle while `out_ready`=1.
- `req_ready` depends combinationally on `req_valid` and `out_ready`. No requester-side signal may depend combinationally on `req_ready`.
- `out_valid`, `out_data` and `out_src` are driven directly from flops.
- `out_data` and `out_src` hold stable while `out_valid & ~out_ready`.

## Configuration

- `MUX_ARB_LOCK_EN` **defined:** burst lock.
  - A `locked` flag and `lock_idx` register are added.
  - An accepted beat with `req_last[g]`=0 sets `locked`=1 and `lock_idx`=g.
  - While locked, the grant is forced to `lock_idx`, even if that requester deasserts valid; other requesters stall.
  - An accepted beat with `req_last`=1 clears `locked` and advances `prio` to `lock_idx+1`.
  - `prio` does not advance on non-last beats.
  - Reset clears `locked`.
- `MUX_ARB_LOCK_EN` **undefined:** `req_last` is ignored. Arbitration is per beat as described above.

## Structure

- **Shared package `mux_arb_pkg`:**
  - `NUM_REQ`=4 and `SEL_W`=2.
  - typedef `sel_t` (logic [SEL_W-1:0]).
  - function `rr_pick(valid, prio)` returning `sel_t` and a found flag.
- **Sub-module `mux4_tree`:** a parameterized WIDTH 4:1 mux built from two 2:1 levels selected by `sel[0]` then `sel[1]`. It is purely combinational and instantiated once.
- Arbiter, handshake logic and output register stay in `mux_rr_arbiter`.

## Test plan

- **Reset:** hold `rst`=1 for 3 cycles with all `req_valid`=1 → `req_ready`=0, `out_valid`=0, `out_data`=0 throughout.
- **Rotation:** all valid, data 0x10/0x21/0x32/0x43, `out_ready`=1 → `out_src` sequence 0,1,2,3,0 starting one cycle after release; `out_data` matches each source.
- **Skip and wrap:** only req 1 and 3 valid, `prio`=0 → grants 1,3,1,3; after a req 3 grant, `prio` wraps to 0.
- **Backpressure:** `out_ready`=0 for 4 cycles with one beat held → `out_data` stable; `req_ready`=0 after the first beat; the next beat loads on the cycle `out_ready` returns, with no bubble.
- **Lock** (`MUX_ARB_LOCK_EN`): req 2 sends 3 beats (last on the 3rd) while req 0 is valid → outputs 2,2,2,0; req 0 is never ready during the burst.
- **Reset mid-burst** (`MUX_ARB_LOCK_EN`): assert `rst` after beat 1 of req 2's burst → the lock clears and the first grant after reset is req 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, select type and the round-robin pick helper for mux_rr_arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // First valid requester scanning prio, prio+1, ... modulo NUM_REQ.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid, input sel_t prio);
        pick_t p;
        sel_t  idx;
        p = '0;
        // Descending scan so the smallest offset from prio is the last write and wins.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = prio + SEL_W'(i);
            if (valid[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester and output channel bundle for mux_rr_arbiter.
interface mux_rr_arbiter_if #(parameter int unsigned WIDTH = 8);
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    sel_t                     out_src;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux4_tree.sv
// Combinational 4:1 mux built as two 2:1 levels (sel[0] first, then sel[1]).
module mux4_tree
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [4*WIDTH-1:0] din,
    input  sel_t               sel,
    output logic [WIDTH-1:0]   dout
);

    logic [WIDTH-1:0] lvl_lo;
    logic [WIDTH-1:0] lvl_hi;

    assign lvl_lo = sel[0] ? din[1*WIDTH +: WIDTH] : din[0*WIDTH +: WIDTH];
    assign lvl_hi = sel[0] ? din[3*WIDTH +: WIDTH] : din[2*WIDTH +: WIDTH];
    assign dout   = sel[1] ? lvl_hi : lvl_lo;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 mux into a registered output.
// Optional burst lock enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    pick_t              pick;
    sel_t               sel;
    logic               any_valid;
    logic               can_load;
    logic               accept;
    logic [NUM_REQ-1:0] grant_vec;
    logic [WIDTH-1:0]   mux_out;

    sel_t               prio;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    sel_t               out_src_q;

`ifdef MUX_ARB_LOCK_EN
    logic               locked;
    sel_t               lock_idx;
`else
    logic               unused_last;
    assign unused_last = ^bus.req_last;
`endif

    // Grant selection, capacity and requester-side ready.
    always_comb begin
        pick      = rr_pick(bus.req_valid, prio);
        sel       = pick.idx;
        any_valid = pick.found;
`ifdef MUX_ARB_LOCK_EN
        if (locked) begin
            sel       = lock_idx;
            any_valid = bus.req_valid[lock_idx];
        end
`endif
        can_load  = ~out_valid_q | bus.out_ready;
        accept    = can_load & any_valid & ~rst;
        grant_vec = '0;
        if (accept) begin
            grant_vec[sel] = 1'b1;
        end
    end

    mux4_tree #(.WIDTH(WIDTH)) u_mux (
        .din  (bus.req_data),
        .sel  (sel),
        .dout (mux_out)
    );

    // Output register, priority pointer and burst lock state.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
`ifdef MUX_ARB_LOCK_EN
            locked      <= 1'b0;
            lock_idx    <= '0;
`endif
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_out;
                out_src_q   <= sel;
`ifdef MUX_ARB_LOCK_EN
                if (bus.req_last[sel]) begin
                    locked <= 1'b0;
                    prio   <= sel + SEL_W'(1);
                end else begin
                    locked   <= 1'b1;
                    lock_idx <= sel;
                end
`else
                prio <= sel + SEL_W'(1);
`endif
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = grant_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter; lock scenarios run when MUX_ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.WIDTH(W)) bus();

    mux_rr_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, kept as plain integers.
    int          m_prio   = 0;
    bit          m_ov     = 0;
    logic [7:0]  m_od     = '0;
    int          m_os     = 0;
    bit          m_locked = 0;
    int          m_lidx   = 0;
    int          m_g      = 0;
    bit          m_acc    = 0;
    bit          m_rst    = 0;
    logic [31:0] m_d      = '0;
    logic [3:0]  m_l      = '0;
    bit          m_ordy   = 0;
    logic [3:0]  exp_ready = '0;

    // Apply inputs mid-cycle and predict the grant from the arbitration rules.
    task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic ordy);
        bit any;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.out_ready = ordy;
        #1;
        m_rst  = r;
        m_d    = d;
        m_l    = l;
        m_ordy = ordy;
        any    = 0;
        m_g    = 0;
        if (m_locked) begin
            m_g = m_lidx;
            any = v[m_lidx];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!any && v[(m_prio + k) % 4]) begin
                    any = 1;
                    m_g = (m_prio + k) % 4;
                end
            end
        end
        m_acc     = !r && any && (!m_ov || ordy);
        exp_ready = m_acc ? 4'(1 << m_g) : 4'b0000;
    endtask

    // Clock once and advance the model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_rst) begin
            m_prio = 0; m_ov = 0; m_od = '0; m_os = 0; m_locked = 0; m_lidx = 0;
        end else if (m_acc) begin
            m_ov = 1;
            m_od = m_d[m_g*8 +: 8];
            m_os = m_g;
`ifdef MUX_ARB_LOCK_EN
            if (m_l[m_g]) begin
                m_locked = 0;
                m_prio   = (m_g + 1) % 4;
            end else begin
                m_locked = 1;
                m_lidx   = m_g;
            end
`else
            m_prio = (m_g + 1) % 4;
`endif
        end else if (m_ordy) begin
            m_ov = 0;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'hF, $urandom, 4'hF, 1'b1);
            n_cmp++;
            if (bus.req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_src !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_out: got v=%b d=%h s=%0d want v=0 d=00 s=0",
                         bus.out_valid, bus.out_data, bus.out_src);
            end
        end
    endtask

    task automatic test_rotation();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'hF, 32'h43322110, 4'hF, 1'b1);
            n_cmp++;
            if (bus.req_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL rot_ready: got %b want %b", bus.req_ready, exp_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_src) != c % 4 ||
                bus.out_data !== 8'((c % 4) * 8'h11 + 8'h10)) begin
                n_bad++;
                $display("FAIL rot_out: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", bus.out_valid,
                         bus.out_src, bus.out_data, c % 4, 8'((c % 4) * 8'h11 + 8'h10));
            end
        end
    endtask

    task automatic test_skip_wrap();
        int exp_src[4] = '{1, 3, 1, 3};
        drive(1'b1, 4'h0, 32'h0, 4'hF, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'b1010, $urandom, 4'hF, 1'b1);
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_src) != exp_src[c] || bus.out_data !== m_od) begin
                n_bad++;
                $display("FAIL skip_out: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         bus.out_valid, bus.out_src, bus.out_data, exp_src[c], m_od);
            end
        end
        drive(1'b0, 4'hF, $urandom, 4'hF, 1'b1);
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_ready: got %b want 0001", bus.req_ready);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        logic [31:0] d;
        drive(1'b1, 4'h0, 32'h0, 4'hF, 1'b1);
        tick();
        d = $urandom;
        drive(1'b0, 4'b0010, d, 4'hF, 1'b1);
        tick();
        held = d[15:8];
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
            n_bad++;
            $display("FAIL bp_first: got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, held);
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'($urandom_range(1, 15)), $urandom, 4'hF, 1'b0);
            n_cmp++;
            if (bus.req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_ready: got %b want 0000", bus.req_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_src !== 2'd1) begin
                n_bad++;
                $display("FAIL bp_hold: got v=%b d=%h s=%0d want v=1 d=%h s=1",
                         bus.out_valid, bus.out_data, bus.out_src, held);
            end
        end
        d = $urandom;
        drive(1'b0, 4'b0100, d, 4'hF, 1'b1);
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL bp_resume_ready: got %b want 0100", bus.req_ready);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d[23:16] || bus.out_src !== 2'd2) begin
            n_bad++;
            $display("FAIL bp_resume_out: got v=%b d=%h s=%0d want v=1 d=%h s=2",
                     bus.out_valid, bus.out_data, bus.out_src, d[23:16]);
        end
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        int exp_src[4] = '{2, 2, 2, 0};
        logic [3:0] last;
        drive(1'b1, 4'h0, 32'h0, 4'hF, 1'b1);
        tick();
        drive(1'b0, 4'b0010, $urandom, 4'hF, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            last = (c == 2) ? 4'b0100 : 4'b0000;
            drive(1'b0, 4'b0101, $urandom, last, 1'b1);
            n_cmp++;
            if (bus.req_ready !== exp_ready || (c < 3 && bus.req_ready[0] !== 1'b0)) begin
                n_bad++;
                $display("FAIL lock_ready: got %b want %b", bus.req_ready, exp_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_src) != exp_src[c] || bus.out_data !== m_od) begin
                n_bad++;
                $display("FAIL lock_out: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         bus.out_valid, bus.out_src, bus.out_data, exp_src[c], m_od);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b1, 4'h0, 32'h0, 4'hF, 1'b1);
        tick();
        drive(1'b0, 4'b0010, $urandom, 4'hF, 1'b1);
        tick();
        drive(1'b0, 4'b0101, $urandom, 4'b0000, 1'b1);
        tick();
        drive(1'b1, 4'b0101, $urandom, 4'b0000, 1'b1);
        tick();
        drive(1'b0, 4'b0101, $urandom, 4'b0000, 1'b1);
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_burst_ready: got %b want 0001", bus.req_ready);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_burst_out: got v=%b s=%0d want v=1 s=0", bus.out_valid, bus.out_src);
        end
    endtask
`endif

    task automatic test_random();
        drive(1'b1, 4'h0, 32'h0, 4'hF, 1'b1);
        tick();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 49) == 0), 4'($urandom), $urandom, 4'($urandom),
                  ($urandom_range(0, 3) != 0));
            n_cmp++;
            if (bus.req_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready, exp_ready);
            end
            tick();
            n_cmp++;
            if (bus.out_valid !== m_ov || (m_ov && (bus.out_data !== m_od || int'(bus.out_src) != m_os))) begin
                n_bad++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c,
                         bus.out_valid, bus.out_data, bus.out_src, m_ov, m_od, m_os);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '1;
        bus.out_ready = 1'b1;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_backpressure();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
        test_reset_mid_burst();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
